// File: rtl/tug_playfield.sv
// Tug-of-war playfield: conditions the two player keys into single-cycle press
// events and moves a one-hot light bar that feeds the victory stage.

module tug_key_cond #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_key,
  input  logic i_en,
  output logic o_pulse
);
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   r_pulse;
  logic                   w_s;
  logic                   w_rise;

  assign w_s     = r_sync[SYNC_STAGES-1];
  assign w_rise  = w_s & ~r_prev;
  assign o_pulse = r_pulse;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync  <= '0;
      r_prev  <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], i_key};
      r_prev  <= w_s;
      r_pulse <= w_rise & i_en;
    end
  end
endmodule

module tug_playfield #(
  parameter int NUM_LIGHTS  = 9,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  key_l,
  input  logic                  key_r,
  input  logic                  freeze,
  output logic                  L,
  output logic                  R,
  output logic [NUM_LIGHTS-1:0] leds,
  output logic                  Llight,
  output logic                  Rlight
);
  localparam int NUM_LANES = 2;
  localparam int PW        = (NUM_LIGHTS > 2) ? $clog2(NUM_LIGHTS) : 1;
  localparam int CENTRE    = (NUM_LIGHTS - 1) / 2;
  localparam int MAX_IDX   = NUM_LIGHTS - 1;
  localparam int WARM      = SYNC_STAGES + 1;
  localparam int WW        = $clog2(WARM + 1);

  logic [NUM_LANES-1:0] w_keys;
  logic [NUM_LANES-1:0] w_pulse;
  logic                 w_armed;
  logic                 w_en;
  logic [WW-1:0]        r_warm;
  logic [PW-1:0]        r_pos;

  // Lane 1 is the left player, lane 0 the right player.
  assign w_keys = {key_l, key_r};

  // After reset the synchroniser and prev fill with the live key level; pulses
  // stay masked until both are full so a key held through reset cannot fire.
  assign w_armed = (r_warm == WW'(WARM));
  assign w_en    = w_armed & ~freeze;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)         r_warm <= '0;
    else if (!w_armed) r_warm <= r_warm + 1'b1;
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    tug_key_cond #(.SYNC_STAGES(SYNC_STAGES)) u_key (
      .clk     (clk),
      .reset   (reset),
      .i_key   (w_keys[g]),
      .i_en    (w_en),
      .o_pulse (w_pulse[g])
    );
  end

  assign L = w_pulse[1];
  assign R = w_pulse[0];

  // Position saturates at both ends; moves on the edge after the L/R pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pos <= PW'(CENTRE);
    end else if (!freeze) begin
      case ({L, R})
        2'b10:   if (r_pos != PW'(MAX_IDX)) r_pos <= r_pos + 1'b1;
        2'b01:   if (r_pos != '0)           r_pos <= r_pos - 1'b1;
        default: r_pos <= r_pos;
      endcase
    end
  end

  for (genvar i = 0; i < NUM_LIGHTS; i++) begin : g_led
    assign leds[i] = (r_pos == PW'(i));
  end

  assign Llight = leds[NUM_LIGHTS-1];
  assign Rlight = leds[0];
endmodule

// File: tb/tb_tug_playfield.sv
// Directed plus randomized bench for tug_playfield against a history-based
// reference model of the key events and bar position.

module tb_tug_playfield;
  localparam int N  = 9;
  localparam int SS = 2;
  localparam int C  = (N - 1) / 2;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         key_l = 1'b0;
  logic         key_r = 1'b0;
  logic         freeze = 1'b0;
  logic         L, R, Llight, Rlight;
  logic [N-1:0] leds;

  int  checks = 0;
  int  failures = 0;
  int  mpos = C;
  bit  mL = 1'b0;
  bit  mR = 1'b0;
  bit  hl[$];
  bit  hr[$];

  tug_playfield #(.NUM_LIGHTS(N), .SYNC_STAGES(SS)) dut (
    .clk    (clk),
    .reset  (reset),
    .key_l  (key_l),
    .key_r  (key_r),
    .freeze (freeze),
    .L      (L),
    .R      (R),
    .leds   (leds),
    .Llight (Llight),
    .Rlight (Rlight)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".L"}, {31'd0, L}, {31'd0, mL});
    chk({tag, ".R"}, {31'd0, R}, {31'd0, mR});
    chk({tag, ".leds"}, {{(32-N){1'b0}}, leds}, 32'd1 << mpos);
    chk({tag, ".Llight"}, {31'd0, Llight}, {31'd0, (mpos == N-1)});
    chk({tag, ".Rlight"}, {31'd0, Rlight}, {31'd0, (mpos == 0)});
  endtask

  // A press event is a 0->1 step in the sampled key sequence, seen SS+1 edges
  // later; edges before both samples exist after reset never produce one.
  task automatic tick(input bit kl, input bit kr, input bit fz, input bit rst);
    int  n;
    bit  nL, nR;
    @(negedge clk);
    key_l = kl; key_r = kr; freeze = fz; reset = rst;
    if (rst) begin
      mpos = C; mL = 1'b0; mR = 1'b0;
      hl.delete(); hr.delete();
      #1 check_outputs("rst_async");
    end
    @(posedge clk);
    if (!rst) begin
      hl.push_back(kl);
      hr.push_back(kr);
      n  = hl.size();
      nL = (n >= SS + 2) && hl[n-1-SS] && !hl[n-2-SS] && !fz;
      nR = (n >= SS + 2) && hr[n-1-SS] && !hr[n-2-SS] && !fz;
      if (!fz) begin
        if (mL && !mR && mpos < N-1)      mpos++;
        else if (mR && !mL && mpos > 0)   mpos--;
      end
      mL = nL;
      mR = nR;
    end
    #1 check_outputs("cyc");
  endtask

  task automatic press(input bit left);
    repeat (2) tick(left, !left, 1'b0, 1'b0);
    repeat (4) tick(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    bit kl, kr, fz, rs;
    // 1: reset state
    repeat (5) tick(0, 0, 0, 1);
    chk("t1.leds", {23'd0, leds}, 32'h010);
    chk("t1.LR", {30'd0, L, R}, 32'd0);
    repeat (6) tick(0, 0, 0, 0);

    // 2: held key gives exactly one pulse, bar moves one place left
    for (int i = 1; i <= 10; i++) begin
      tick(1, 0, 0, 0);
      if (i == 3) chk("t2.Lpulse", {31'd0, L}, 32'd1);
      if (i >= 4) chk("t2.leds", {23'd0, leds}, 32'h020);
    end
    repeat (4) tick(0, 0, 0, 0);

    // 3: walk to the left end, then press again at the end
    press(0);
    chk("t3.centre", {23'd0, leds}, 32'h010);
    repeat (4) press(1);
    chk("t3.leds_end", {23'd0, leds}, 32'h100);
    chk("t3.Llight", {31'd0, Llight}, 32'd1);
    tick(1, 0, 0, 0); tick(1, 0, 0, 0); tick(0, 0, 0, 0);
    chk("t3.victory", {30'd0, L, Llight}, 32'd3);
    repeat (3) tick(0, 0, 0, 0);
    chk("t3.saturate", {23'd0, leds}, 32'h100);

    // 4: simultaneous presses, bar holds
    repeat (4) press(0);
    tick(1, 1, 0, 0); tick(1, 1, 0, 0); tick(0, 0, 0, 0);
    chk("t4.LR", {30'd0, L, R}, 32'd3);
    repeat (3) tick(0, 0, 0, 0);
    chk("t4.leds", {23'd0, leds}, 32'h010);

    // 5: freeze masks presses; held key across release does not fire
    repeat (2) tick(0, 0, 1, 0);
    for (int i = 0; i < 6; i++) begin
      tick(0, 1, 1, 0);
      chk("t5.frozenR", {31'd0, R}, 32'd0);
    end
    for (int i = 0; i < 6; i++) begin
      tick(0, 1, 0, 0);
      chk("t5.heldR", {31'd0, R}, 32'd0);
    end
    chk("t5.hold", {23'd0, leds}, 32'h010);
    repeat (3) tick(0, 0, 0, 0);
    press(0);
    chk("t5.moved", {23'd0, leds}, 32'h008);

    // 6: reset mid-press with the light near the right end
    repeat (2) press(0);
    chk("t6.bit1", {23'd0, leds}, 32'h002);
    tick(0, 1, 0, 0); tick(0, 1, 0, 0);
    tick(0, 1, 0, 1);
    chk("t6.reset_leds", {23'd0, leds}, 32'h010);
    repeat (2) tick(0, 1, 0, 1);
    for (int i = 0; i < 10; i++) begin
      tick(0, 1, 0, 0);
      chk("t6.noR", {31'd0, R}, 32'd0);
    end
    repeat (3) tick(0, 0, 0, 0);
    press(0);
    chk("t6.after", {23'd0, leds}, 32'h008);

    // Randomized play against the model
    kl = 0; kr = 0; fz = 0; rs = 0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(3) == 0) kl = ~kl;
      if ($urandom_range(3) == 0) kr = ~kr;
      if ($urandom_range(24) == 0) fz = ~fz;
      rs = ($urandom_range(149) == 0);
      tick(kl, kr, fz, rs);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/tug_playfield.md
Name: tug_playfield

Overview:
Upstream neighbour of the victory detector in the tug-of-war game. Conditions the two raw player keys and produces single-cycle press events L/R. Maintains the one-hot light bar (the "rope" position) and exports its two end lights as Llight/Rlight. The victory block combines these four signals to decide the winner and drive the hex display.

Parameters:
NUM_LIGHTS, 9, number of bar lights; odd and >= 3; centre index is (NUM_LIGHTS-1)/2
SYNC_STAGES, 2, flip-flop stages in each key synchroniser; >= 2

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
key_l  input  1  raw left-player key, active-high, asynchronous to clk
key_r  input  1  raw right-player key, active-high, asynchronous to clk
freeze  input  1  game-over hold from the victory stage; active-high
L  output  1  left press event, one clk wide, registered
R  output  1  right press event, one clk wide, registered
leds  output  NUM_LIGHTS  one-hot light bar; bit NUM_LIGHTS-1 = leftmost
Llight  output  1  equals leds[NUM_LIGHTS-1]
Rlight  output  1  equals leds[0]

Behaviour:
- Reset (async assert, sync release):
  - all synchroniser and edge flops = 0; L = R = 0
  - leds = only the centre bit set (9'b000010000 for the default); Llight = Rlight = 0
- Synchroniser: each key passes through SYNC_STAGES flops; the last stage is s.
- Edge detect:
  - prev <= s
  - next L <= s_l & ~prev_l & ~freeze; same form for R
  - rise_l is the value feeding L, i.e. s_l & ~prev_l
- Latency with SYNC_STAGES=2: key rises before edge 1, so L is high after edge 3, for exactly one cycle. Each extra stage adds one cycle.
- Held key: one L pulse per low-to-high transition; no repeat while held.
- Glitch shorter than one clk: may or may not produce a pulse, but never more than one.
- L and R are independent; both may be high in the same cycle.
- Light bar update, on each edge, using the registered L/R:
  - L=1, R=0: the lit bit shifts one place left. If already at bit NUM_LIGHTS-1, it holds (no wrap).
  - R=1, L=0: the lit bit shifts one place right. If already at bit 0, it holds (no wrap).
  - L=R=1 or L=R=0: hold.
  - The update occurs one edge after the L/R pulse. During the pulse cycle, Llight/Rlight still show the pre-move position, so the victory stage sees Llight&L when the light is at the end and the player presses again.
- freeze=1:
  - L/R outputs forced 0 from the next edge
  - leds hold
  - synchroniser and prev keep running, so a key held across the freeze release does not generate a pulse
- Invariant: leds is exactly one-hot at all times out of reset. Implementation holds the position as an index of ceil(log2(NUM_LIGHTS)) bits, saturating at 0 and NUM_LIGHTS-1, and decodes it to leds.
- Reset mid-press: outputs return to reset values immediately. A key still held at release does not pulse until it is released and pressed again, because the synchroniser and prev both fill with 1 before any L can assert.

Test Plan:
1. Reset, keys low, 5 cycles -> leds=9'b000010000, L=R=0, Llight=Rlight=0.
2. key_l 0->1, held 10 cycles -> L high only in the cycle after edge 3. leds=9'b000100000 after edge 4; no further change while held.
3. 4 separate key_l presses from centre, then a 5th press -> after the 4th press leds=9'b100000000 and Llight=1. On the 5th press L=1 while Llight=1 (victory condition), and leds remain 9'b100000000 afterwards.
4. key_l and key_r rise on the same cycle -> L=R=1 in the same cycle; leds unchanged at centre.
5. freeze=1, then key_r presses -> R stays 0, leds hold. Release freeze with key_r still held -> no pulse. Release key_r and press again -> R pulses, bar moves right by one.
6. Assert reset mid-game with the light at bit 1 and key_r held -> leds=9'b000010000 immediately. After release, no R pulse until key_r is released and re-pressed.
